uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tx_data  input  8  byte to transmit, sampled only on the accept cycle.
REQ-005 SHALL have port tx_data_valid  input  1  transmit request, single-cycle pulse or level.
REQ-006 SHALL have port tx_data_ack  output  1  one-cycle pulse marking frame completion.
REQ-007 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port txd  output  1  serial line, idle high, driven from a flop.
REQ-009 SHALL have port tx_overrun  output  1  sticky flag for a request dropped while busy.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tx_busy = (state != IDLE).
REQ-011 SHALL accept a request when state==IDLE and tx_data_valid==1: latch tx_data into a shift register, enter START, clear bit counter and baud counter.
REQ-012 SHALL drive txd=0 from the clock edge that accepts the request, i.e. zero-cycle added latency after the accept edge.
REQ-013 SHALL hold each serial bit for exactly CLK_DIV cycles; baud counter counts 0..CLK_DIV-1, bit boundary at CLK_DIV-1, then wraps to 0.
REQ-014 SHALL send data LSB first in DATA; 3-bit index 0..7; leave DATA after index 7 completes.
REQ-015 SHALL drive txd=1 in STOP for one bit time (one stop bit).
REQ-016 SHALL assert tx_data_ack for exactly one cycle: the cycle where state==STOP and baud counter==CLK_DIV-1.
REQ-017 SHALL return to IDLE on the edge ending that cycle; tx_busy stays high for exactly N*CLK_DIV cycles per frame (N=10, or 11 with parity).
REQ-018 SHALL ignore tx_data_valid in the ack cycle (still busy); back-to-back frames start earliest one cycle after ack.
REQ-019 SHALL set tx_overrun when tx_data_valid==1 and tx_busy==1, including the ack cycle; the in-flight frame is unaffected; the flag clears only on reset.
REQ-020 SHALL ignore tx_data changes after the accept edge.
REQ-021 SHALL keep txd=1, tx_data_ack=0 and counters at 0 while in IDLE.

Reset
REQ-022 SHALL, when rst==1 at a clock edge, set state=IDLE, txd=1, tx_data_ack=0, tx_busy=0, tx_overrun=0, and shift register, bit counter and baud counter to 0.
REQ-023 SHALL abort a frame when reset occurs mid-frame: txd high on the next edge, no ack pulse, and the byte discarded.
REQ-024 SHALL give rst priority over tx_data_valid in the same cycle.

Configuration
REQ-025 SHALL use macro SOC2_UART_TX_PARITY_EN to compile in the parity feature.
REQ-026 With SOC2_UART_TX_PARITY_EN defined, SHALL insert PARITY between DATA and STOP, driving even parity (XOR of the 8 data bits) for one bit time, for an 11-bit frame.
REQ-027 Without the macro, SHALL omit the PARITY state and logic, with DATA going directly to STOP for a 10-bit frame; ports are identical in both builds.

Verification (CLK_DIV=4)
REQ-028 SHALL cover: reset, then pulse valid with 0x55 -> txd from accept edge: 0,1,0,1,0,1,0,1,0,1, each 4 cycles; ack at cycle 39 after accept; busy high for 40 cycles.
REQ-029 SHALL cover: parity build, send 0x07 -> parity bit 1, ack at cycle 43; send 0x55 -> parity bit 0.
REQ-030 SHALL cover: valid held high continuously with 0xA3 -> frames back-to-back with a 1-cycle idle gap after each ack; tx_overrun=1 after the first busy cycle.
REQ-031 SHALL cover: tx_data changed to 0xFF mid-frame after accepting 0x00 -> all data bits 0 on the line.
REQ-032 SHALL cover: rst asserted during DATA bit 3 -> next edge txd=1, busy=0, overrun=0, no ack; a new 0x81 frame then transmits correctly.
REQ-033 SHALL cover: valid in the ack cycle -> ignored, overrun=1, no new frame started.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, CLK_DIV clk cycles per bit.
// Define SOC2_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ack,
    output logic       tx_busy,
    output logic       txd,
    output logic       tx_overrun
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef SOC2_UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [15:0] LAST  = 16'(CLK_DIV - 1);

    logic [2:0]  state;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] baud_cnt;

    // Status outputs decode straight from registered state, so they are glitch-free.
    assign tx_busy     = state != IDLE;
    assign tx_data_ack = state == STOP && baud_cnt == LAST;

    // Frame sequencer: txd is registered and already carries the start bit on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            txd        <= 1'b1;
            tx_overrun <= 1'b0;
        end else begin
            if (tx_data_valid && state != IDLE)
                tx_overrun <= 1'b1;
            if (state == IDLE) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
                txd      <= !tx_data_valid;
                if (tx_data_valid) begin
                    shreg <= tx_data;
                    state <= START;
                end
            end else if (baud_cnt != LAST) begin
                baud_cnt <= baud_cnt + 16'd1;
            end else begin
                baud_cnt <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
`ifdef SOC2_UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= ^shreg;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[bit_cnt + 3'd1];
                        end
                    end
`ifdef SOC2_UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
`endif
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        txd     <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CLK_DIV=4.
module tb_uart_tx;
    localparam int DIV = 4;
`ifdef SOC2_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_ack;
    logic       tx_busy;
    logic       txd;
    logic       tx_overrun;
    int         passed = 0;
    int         total = 0;

    uart_tx #(.CLK_DIV(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ack(tx_data_ack),
        .tx_busy(tx_busy),
        .txd(txd),
        .tx_overrun(tx_overrun)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (i == 9 && NB == 11) return ^d;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic idle_check(input string tag, input logic ovr);
        @(negedge clk);
        check(tag, {txd, tx_busy, tx_data_ack, tx_overrun}, {1'b1, 1'b0, 1'b0, ovr});
    endtask

    // Walks one frame cycle by cycle from the accept edge, checking {txd,busy,ack}.
    task automatic frame(input logic [7:0] d, input logic [7:0] alt, input logic hold,
                         input logic ack_req, input logic ovr0);
        for (int k = 0; k < NB * DIV; k++) begin
            @(negedge clk);
            check($sformatf("frame%02h_c%0d", d, k), {1'b0, txd, tx_busy, tx_data_ack},
                  {1'b0, frame_bit(d, k / DIV), 1'b1, k == NB * DIV - 1});
            if (hold && k < 2)
                check($sformatf("ovr%02h_c%0d", d, k), {3'b000, tx_overrun}, {3'b000, k == 0 ? ovr0 : 1'b1});
            if (k == 0) begin
                if (!hold) tx_data_valid = 1'b0;
                tx_data = alt;
            end
            if (k == NB * DIV - 1 && ack_req) tx_data_valid = 1'b1;
        end
    endtask

    initial begin
        tx_data_valid = 1'b1;
        tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset", {txd, tx_busy, tx_data_ack, tx_overrun}, 4'b1000);
        rst = 1'b0;
        tx_data_valid = 1'b0;
        idle_check("idle", 1'b0);

        tx_data = 8'h55; tx_data_valid = 1'b1;
        frame(8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        idle_check("after55", 1'b0);

        tx_data = 8'h07; tx_data_valid = 1'b1;
        frame(8'h07, 8'h07, 1'b0, 1'b0, 1'b0);
        idle_check("after07", 1'b0);

        tx_data = 8'h00; tx_data_valid = 1'b1;
        frame(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle_check("after00", 1'b0);

        tx_data = 8'h3C; tx_data_valid = 1'b1;
        frame(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
        idle_check("ackvalid", 1'b1);
        tx_data_valid = 1'b0;
        idle_check("ackvalid_nostart", 1'b1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_check("rst_clears_ovr", 1'b0);

        tx_data = 8'hA3; tx_data_valid = 1'b1;
        frame(8'hA3, 8'hA3, 1'b1, 1'b0, 1'b0);
        idle_check("gap1", 1'b1);
        frame(8'hA3, 8'hA3, 1'b1, 1'b0, 1'b1);
        idle_check("gap2", 1'b1);
        tx_data_valid = 1'b0;
        idle_check("hold_end", 1'b1);

        tx_data = 8'h5A; tx_data_valid = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0) tx_data_valid = 1'b0;
        end
        check("mid_bit3", {3'b000, txd}, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        check("midrst", {txd, tx_busy, tx_data_ack, tx_overrun}, 4'b1000);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) idle_check($sformatf("noack%0d", k), 1'b0);

        tx_data = 8'h81; tx_data_valid = 1'b1;
        frame(8'h81, 8'h81, 1'b0, 1'b0, 1'b0);
        idle_check("after81", 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
